jtframe_spi_upload: RTL and testbench



---
 rtl/jtframe_spi_upload.sv | 127 ++++++++++++
 tb/tb_jtframe_spi_upload.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/jtframe_spi_upload.sv
// SPI responder that streams game memory back to the I/O controller.
// Decodes start/data commands, walks ioctl_addr and shifts prefetched bytes out on spi_do.
module jtframe_spi_upload #(
  parameter int         AW        = 25,
  parameter logic [7:0] CMD_START = 8'h57,
  parameter logic [7:0] CMD_DATA  = 8'h58,
  parameter int         RDLAT     = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          spi_sck,
  input  logic          spi_ss,
  input  logic          spi_di,
  output logic          spi_do,
  output logic          spi_do_en,
  output logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_din,
  output logic          ioctl_ram,
  output logic          upload_busy
);

  localparam int PW = $clog2(RDLAT + 1);

  typedef enum logic [2:0] {IDLE, CMD, ARG, DATA, DISCARD} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [2:0]    r_sck_s;
  logic [2:0]    r_ss_s;
  logic [1:0]    r_di_s;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_rx;
  logic [7:0]    r_shreg;
  logic [7:0]    r_dbuf;
  logic [PW-1:0] r_pf_cnt;

  logic       w_ss;
  logic       w_ss_fall;
  logic       w_rise;
  logic       w_fall;
  logic       w_byte_done;
  logic [7:0] w_byte;
  logic       w_load;
  logic       w_shift;
  logic       w_arg_done;

  assign w_ss        = r_ss_s[1];
  assign w_ss_fall   = r_ss_s[2] & ~r_ss_s[1];
  assign w_rise      = r_sck_s[1] & ~r_sck_s[2] & ~w_ss;
  assign w_fall      = ~r_sck_s[1] & r_sck_s[2] & ~w_ss;
  assign w_byte_done = w_rise && (r_bit_cnt == 3'd7);
  assign w_byte      = {r_rx[6:0], r_di_s[1]};
  assign w_load      = (r_state == DATA) && w_fall && (r_bit_cnt == 3'd0);
  assign w_shift     = (r_state == DATA) && w_fall && (r_bit_cnt != 3'd0);
  assign w_arg_done  = (r_state == ARG) && w_byte_done;

  assign spi_do      = r_shreg[7];
  assign spi_do_en   = (r_state == DATA);
  assign upload_busy = (r_state == DATA);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_ss_fall) w_next = CMD;
      CMD: begin
        if (w_byte_done) begin
          if (w_byte == CMD_START)                 w_next = ARG;
          else if (w_byte == CMD_DATA && ioctl_ram) w_next = DATA;
          else                                      w_next = DISCARD;
        end
      end
      ARG:     if (w_byte_done) w_next = DISCARD;
      DATA:    w_next = DATA;
      DISCARD: w_next = DISCARD;
      default: w_next = IDLE;
    endcase
    // A deselect always aborts the frame, whatever the state.
    if (w_ss) w_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      // ss chain resets low so a frame already in progress is not seen as a new select.
      r_sck_s   <= 3'b000;
      r_ss_s    <= 3'b000;
      r_di_s    <= 2'b00;
      r_bit_cnt <= 3'd0;
      r_rx      <= 8'h00;
      r_shreg   <= 8'h00;
      r_dbuf    <= 8'h00;
      r_pf_cnt  <= '0;
      ioctl_addr <= '0;
      ioctl_ram  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sck_s <= {r_sck_s[1:0], spi_sck};
      r_ss_s  <= {r_ss_s[1:0], spi_ss};
      r_di_s  <= {r_di_s[0], spi_di};

      if (w_ss)        r_bit_cnt <= 3'd0;
      else if (w_rise) r_bit_cnt <= r_bit_cnt + 3'd1;

      if (w_rise) r_rx <= w_byte;

      if (w_load)       r_shreg <= r_dbuf;
      else if (w_shift) r_shreg <= {r_shreg[6:0], 1'b0};

      if (r_pf_cnt != '0) begin
        r_pf_cnt <= r_pf_cnt - 1'b1;
        if (r_pf_cnt == PW'(1)) r_dbuf <= ioctl_din;
      end

      if (w_arg_done) begin
        ioctl_ram <= w_byte[0];
        if (w_byte[0]) begin
          ioctl_addr <= '0;
          r_pf_cnt   <= PW'(RDLAT);
        end
      end else if (w_load) begin
        ioctl_addr <= ioctl_addr + {{(AW-1){1'b0}}, 1'b1};
        r_pf_cnt   <= PW'(RDLAT);
      end
    end
  end

endmodule

// File: tb/tb_jtframe_spi_upload.sv
// Directed bench: drives SPI frames into a 25-bit and a 4-bit address instance sharing the bus.
module tb_jtframe_spi_upload;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, sck, ss, di;
  logic do_a, en_a, ram_a, busy_a;
  logic [24:0] addr_a;
  logic [7:0]  din_a;
  logic do_b, en_b, ram_b, busy_b;
  logic [3:0]  addr_b;
  logic [7:0]  din_b;

  int errors = 0;
  int checks = 0;

  jtframe_spi_upload #(.AW(25)) dut_a (
    .clk(clk), .rst_n(rst_n), .spi_sck(sck), .spi_ss(ss), .spi_di(di),
    .spi_do(do_a), .spi_do_en(en_a), .ioctl_addr(addr_a), .ioctl_din(din_a),
    .ioctl_ram(ram_a), .upload_busy(busy_a)
  );

  jtframe_spi_upload #(.AW(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .spi_sck(sck), .spi_ss(ss), .spi_di(di),
    .spi_do(do_b), .spi_do_en(en_b), .ioctl_addr(addr_b), .ioctl_din(din_b),
    .ioctl_ram(ram_b), .upload_busy(busy_b)
  );

  // Memory model: mem[a] = a ^ 8'hA5, registered read.
  always @(posedge clk) begin
    din_a <= addr_a[7:0] ^ 8'hA5;
    din_b <= {4'h0, addr_b} ^ 8'hA5;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame_start();
    @(negedge clk);
    ss = 1'b0;
    #100;
  endtask

  // One SPI mode-0 byte; with last=1 ss rises together with the final falling edge.
  task automatic spi_byte(input logic [7:0] tx, input bit last,
                          output logic [7:0] rx_a, output logic [7:0] rx_b,
                          output bit en_all, output bit en_any);
    en_all = 1'b1;
    en_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      di = tx[i];
      #50;
      rx_a[i] = do_a;
      rx_b[i] = do_b;
      en_all &= (en_a === 1'b1);
      en_any |= (en_a === 1'b1);
      sck = 1'b1;
      #50;
      sck = 1'b0;
      if (last && i == 0) ss = 1'b1;
    end
    $display("spi byte tx=%02h rx_a=%02h rx_b=%02h en_all=%0d en_any=%0d", tx, rx_a, rx_b, en_all, en_any);
  endtask

  logic [7:0] ra, rb;
  bit ea, eany;
  logic [7:0] exp4 [4];
  logic [7:0] exp2 [2];

  initial begin
    exp4[0] = 8'hA5; exp4[1] = 8'hA4; exp4[2] = 8'hA7; exp4[3] = 8'hA6;
    exp2[0] = 8'hA1; exp2[1] = 8'hA0;
    rst_n = 1'b0; sck = 1'b0; ss = 1'b1; di = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_do", 32'(do_a), 32'd0);
    chk("rst_en", 32'(en_a), 32'd0);
    chk("rst_addr", 32'(addr_a), 32'd0);
    chk("rst_ram", 32'(ram_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_en", 32'(en_a), 32'd0);
    chk("idle_addr", 32'(addr_a), 32'd0);

    // Session start
    frame_start();
    spi_byte(8'h57, 1'b0, ra, rb, ea, eany);
    spi_byte(8'h01, 1'b1, ra, rb, ea, eany);
    #100;
    chk("start_ram", 32'(ram_a), 32'd1);
    chk("start_addr", 32'(addr_a), 32'd0);
    chk("start_dbuf", 32'(dut_a.r_dbuf), 32'hA5);

    // Four data bytes
    frame_start();
    spi_byte(8'h58, 1'b0, ra, rb, ea, eany);
    chk("cmd_en_low", 32'(eany), 32'd0);
    for (int k = 0; k < 4; k++) begin
      spi_byte(8'h00, k == 3, ra, rb, ea, eany);
      chk($sformatf("data4_byte%0d", k), 32'(ra), 32'(exp4[k]));
      chk($sformatf("data4_en%0d", k), 32'(ea), 32'd1);
    end
    #100;
    chk("data4_addr", 32'(addr_a), 32'd4);
    chk("data4_en_after", 32'(en_a), 32'd0);

    // Next frame continues where the previous stopped
    frame_start();
    spi_byte(8'h58, 1'b0, ra, rb, ea, eany);
    for (int k = 0; k < 2; k++) begin
      spi_byte(8'h00, k == 1, ra, rb, ea, eany);
      chk($sformatf("data2_byte%0d", k), 32'(ra), 32'(exp2[k]));
    end
    @(posedge clk); #1;
    chk("busy_hold", 32'(busy_a), 32'd1);
    repeat (2) @(posedge clk); #1;
    chk("busy_fall", 32'(busy_a), 32'd0);
    #100;
    chk("data2_addr", 32'(addr_a), 32'd6);

    // Unknown command
    frame_start();
    spi_byte(8'h12, 1'b0, ra, rb, ea, eany);
    spi_byte(8'h00, 1'b1, ra, rb, ea, eany);
    chk("unk_en", 32'(eany), 32'd0);
    #100;
    chk("unk_addr", 32'(addr_a), 32'd6);
    chk("unk_ram", 32'(ram_a), 32'd1);

    // Session stop, then a data read is discarded
    frame_start();
    spi_byte(8'h57, 1'b0, ra, rb, ea, eany);
    spi_byte(8'h00, 1'b1, ra, rb, ea, eany);
    #100;
    chk("stop_ram", 32'(ram_a), 32'd0);
    frame_start();
    spi_byte(8'h58, 1'b0, ra, rb, ea, eany);
    spi_byte(8'h00, 1'b1, ra, rb, ea, eany);
    chk("stop_en", 32'(eany), 32'd0);
    #100;
    chk("stop_addr", 32'(addr_a), 32'd6);

    // Wrap on the 4-bit instance
    frame_start();
    spi_byte(8'h57, 1'b0, ra, rb, ea, eany);
    spi_byte(8'h01, 1'b1, ra, rb, ea, eany);
    #100;
    chk("wrap_start_addr", 32'(addr_b), 32'd0);
    frame_start();
    spi_byte(8'h58, 1'b0, ra, rb, ea, eany);
    for (int k = 0; k < 17; k++) begin
      spi_byte(8'h00, k == 16, ra, rb, ea, eany);
      if (k == 0)  chk("wrap_byte1", 32'(rb), 32'hA5);
      if (k == 15) chk("wrap_byte16", 32'(rb), 32'hAA);
      if (k == 16) chk("wrap_byte17", 32'(rb), 32'hA5);
    end
    #100;
    chk("wrap_addr4", 32'(addr_b), 32'd1);
    chk("wrap_addr25", 32'(addr_a), 32'd17);

    // Reset in the middle of a data byte
    frame_start();
    spi_byte(8'h58, 1'b0, ra, rb, ea, eany);
    for (int i = 0; i < 4; i++) begin
      #50; sck = 1'b1; #50; sck = 1'b0;
    end
    #50;
    chk("midrst_busy_before", 32'(busy_b), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_en", 32'(en_b), 32'd0);
    chk("midrst_busy", 32'(busy_b), 32'd0);
    chk("midrst_addr", 32'(addr_b), 32'd0);
    chk("midrst_ram", 32'(ram_b), 32'd0);
    chk("midrst_do", 32'(do_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ss = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("postrst_busy", 32'(busy_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
